// File: rtl/juego_pkg.sv
// rtl/juego_pkg.sv - shared types and helpers for the 2048 controller and move datapaths
package juego_pkg;

  typedef int board_t [4][4];
  typedef int line_t [4];

  typedef enum logic [2:0] {INIT, SPAWN, SPAWN2, WAIT, APPLY, CHECK, WINST, LOSEST} estado_t;
  typedef enum logic [1:0] {DER, IZQ, ARR, ABA} dir_t;

  // Cell-by-cell equality of two boards
  function automatic logic board_eq(input board_t a, input board_t b);
    logic eq;
    eq = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (a[r][c] != b[r][c]) eq = 1'b0;
    return eq;
  endfunction

  // Slide one line toward index 0, then merge equal neighbours once, leading edge first
  function automatic void merge_line(input line_t lane, output line_t merged);
    int         comp [8];
    logic [2:0] n;
    logic [1:0] m;
    logic       skip;
    comp   = '{default: 0};
    merged = '{default: 0};
    n      = '0;
    m      = '0;
    skip   = 1'b0;
    for (int i = 0; i < 4; i++)
      if (lane[i] != 0) begin
        comp[n] = lane[i];
        n = n + 3'd1;
      end
    // comp[4] is always zero, so the i+1 lookahead never pairs a real tile with padding
    for (int i = 0; i < 4; i++) begin
      if (skip) skip = 1'b0;
      else if (comp[i] != 0) begin
        if (comp[i] == comp[i+1]) begin
          merged[m] = 2 * comp[i];
          skip = 1'b1;
        end else begin
          merged[m] = comp[i];
        end
        m = m + 2'd1;
      end
    end
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR, taps 16,14,13,11, free running outside reset
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  // Shift left, feeding back the XOR of the tap bits
  always_ff @(posedge clk) begin
    if (rst) q <= seed;
    else     q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end
endmodule

// File: rtl/mov_abajo.sv
// rtl/mov_abajo.sv - slide and merge every column toward row 3
module mov_abajo
  import juego_pkg::*;
(
  input  board_t board,
  output board_t result
);
  line_t lane, merged;
  // Read each column bottom-up so merging runs toward row 3
  always_comb begin
    result = '{default: 0};
    lane   = '{default: 0};
    merged = '{default: 0};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) lane[j] = board[3-j][c];
      merge_line(lane, merged);
      for (int j = 0; j < 4; j++) result[3-j][c] = merged[j];
    end
  end
endmodule

// File: rtl/mov_arriba.sv
// rtl/mov_arriba.sv - slide and merge every column toward row 0
module mov_arriba
  import juego_pkg::*;
(
  input  board_t board,
  output board_t result
);
  line_t lane, merged;
  // Read each column top-down so merging runs toward row 0
  always_comb begin
    result = '{default: 0};
    lane   = '{default: 0};
    merged = '{default: 0};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) lane[j] = board[j][c];
      merge_line(lane, merged);
      for (int j = 0; j < 4; j++) result[j][c] = merged[j];
    end
  end
endmodule

// File: rtl/mov_derecha.sv
// rtl/mov_derecha.sv - slide and merge every row toward column 3
module mov_derecha
  import juego_pkg::*;
(
  input  board_t board,
  output board_t result
);
  line_t lane, merged;
  // Read each row from column 3 inward so merging runs toward the right edge
  always_comb begin
    result = '{default: 0};
    lane   = '{default: 0};
    merged = '{default: 0};
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) lane[j] = board[r][3-j];
      merge_line(lane, merged);
      for (int j = 0; j < 4; j++) result[r][3-j] = merged[j];
    end
  end
endmodule

// File: rtl/mov_izquierda.sv
// rtl/mov_izquierda.sv - slide and merge every row toward column 0
module mov_izquierda
  import juego_pkg::*;
(
  input  board_t board,
  output board_t result
);
  line_t lane, merged;
  // Rows already run toward column 0, so they feed the merger directly
  always_comb begin
    result = '{default: 0};
    lane   = '{default: 0};
    merged = '{default: 0};
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) lane[j] = board[r][j];
      merge_line(lane, merged);
      for (int j = 0; j < 4; j++) result[r][j] = merged[j];
    end
  end
endmodule

// File: rtl/control_juego.sv
// rtl/control_juego.sv - 2048 game sequencer: board register, move apply, tile spawn, win/lose
module control_juego
  import juego_pkg::*;
#(
  parameter int          WIN_VALUE = 2048,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   btn_right,
  input  logic   btn_left,
  input  logic   btn_up,
  input  logic   btn_down,
  input  logic   load_en,
  input  board_t load_board,
  output board_t board,
  output logic   busy,
  output logic   moved,
  output logic   win,
  output logic   lose
);
  estado_t     state, state_nx;
  dir_t        dir;
  logic [15:0] lfsr;
  logic        unused_lfsr;
  board_t      b_der, b_izq, b_arr, b_aba, b_cmd;
  logic        cmd_valid, cmd_changed;
  logic        any_win, any_zero, stuck;
  logic [3:0]  scan_cnt, scan_idx, cur_idx;
  int          scan_val, cur_val;
  logic        cur_empty, scan_done, spawning, first_spawn;

  lfsr16 u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .q(lfsr));
  assign unused_lfsr = ^lfsr[15:8];

  mov_derecha   u_der (.board(board), .result(b_der));
  mov_izquierda u_izq (.board(board), .result(b_izq));
  mov_arriba    u_arr (.board(board), .result(b_arr));
  mov_abajo     u_aba (.board(board), .result(b_aba));

  assign busy     = (state != WAIT);
  assign spawning = (state == SPAWN) || (state == SPAWN2);

  // Pick the command by fixed priority right > left > up > down and see if it changes anything
  always_comb begin
    cmd_valid = btn_right | btn_left | btn_up | btn_down;
    dir = ABA;
    if (btn_right)     dir = DER;
    else if (btn_left) dir = IZQ;
    else if (btn_up)   dir = ARR;
    case (dir)
      DER: b_cmd = b_der;
      IZQ: b_cmd = b_izq;
      ARR: b_cmd = b_arr;
      ABA: b_cmd = b_aba;
    endcase
    cmd_changed = !board_eq(b_cmd, board);
  end

  // Board-wide status used by CHECK: a winning tile, any hole, or no move left
  always_comb begin
    any_win  = 1'b0;
    any_zero = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (board[r][c] >= WIN_VALUE) any_win = 1'b1;
        if (board[r][c] == 0)         any_zero = 1'b1;
      end
    stuck = !any_zero && board_eq(b_der, board) && board_eq(b_izq, board) &&
            board_eq(b_arr, board) && board_eq(b_aba, board);
  end

  // Spawn scan: the first cycle takes position and value from the LFSR, later cycles step on
  always_comb begin
    cur_idx   = (scan_cnt == 4'd0) ? lfsr[3:0] : scan_idx;
    cur_val   = (scan_cnt == 4'd0) ? ((lfsr[7:4] == 4'd0) ? 4 : 2) : scan_val;
    cur_empty = (board[cur_idx[3:2]][cur_idx[1:0]] == 0);
    scan_done = cur_empty || (scan_cnt == 4'd15);
  end

  // Next-state decode; a load overrides whatever the FSM was doing
  always_comb begin
    state_nx = state;
    if (load_en) begin
      state_nx = CHECK;
    end else begin
      case (state)
        INIT:   state_nx = SPAWN;
        SPAWN:  if (scan_done) state_nx = first_spawn ? SPAWN2 : CHECK;
        SPAWN2: if (scan_done) state_nx = WAIT;
        WAIT:   if (cmd_valid) state_nx = APPLY;
        APPLY:  state_nx = moved ? SPAWN : WAIT;
        CHECK:  state_nx = any_win ? WINST : (stuck ? LOSEST : WAIT);
        WINST:  state_nx = WINST;
        LOSEST: state_nx = LOSEST;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  // Board, flags and scan bookkeeping; the move is latched as it leaves WAIT so board and moved land together
  always_ff @(posedge clk) begin
    if (rst) begin
      board       <= '{default: 0};
      win         <= 1'b0;
      lose        <= 1'b0;
      moved       <= 1'b0;
      scan_cnt    <= '0;
      scan_idx    <= '0;
      scan_val    <= 0;
      first_spawn <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (load_en) begin
        board <= load_board;
        win   <= 1'b0;
        lose  <= 1'b0;
      end else begin
        case (state)
          WAIT: if (cmd_valid) begin
            board <= b_cmd;
            moved <= cmd_changed;
          end
          SPAWN, SPAWN2: if (cur_empty) board[cur_idx[3:2]][cur_idx[1:0]] <= cur_val;
          CHECK: begin
            if (any_win)    win  <= 1'b1;
            else if (stuck) lose <= 1'b1;
          end
          default: ;
        endcase
      end

      if (!load_en && spawning && !scan_done) begin
        scan_cnt <= scan_cnt + 4'd1;
        scan_idx <= cur_idx + 4'd1;
        scan_val <= cur_val;
      end else begin
        scan_cnt <= '0;
      end

      if (load_en)                       first_spawn <= 1'b0;
      else if (state == INIT)            first_spawn <= 1'b1;
      else if (state == SPAWN && scan_done) first_spawn <= 1'b0;
    end
  end

endmodule
